// File: rtl/mem_ctrl.sv
// rtl/mem_ctrl.sv - single-port byte RAM arbiter between fetch stream and load/store buffer
module mem_ctrl #(
  parameter logic [1:0] IO_SEL = 2'b11
) (
  input  logic        clk_in,
  input  logic        rst_in,
  input  logic        rdy_in,
  input  logic        io_buffer_full,
  input  logic        if_req,
  input  logic [31:0] if_addr,
  output logic        if_grant,
  input  logic        lsb_req,
  input  logic        lsb_we,
  input  logic [1:0]  lsb_len,
  input  logic [31:0] lsb_addr,
  input  logic [31:0] lsb_wdata,
  input  logic        lsb_flush,
  output logic        lsb_done,
  output logic [31:0] lsb_rdata,
  output logic [31:0] ram_a,
  output logic        ram_wr,
  output logic [7:0]  ram_dout,
  input  logic [7:0]  ram_din
);

  typedef enum logic [1:0] {S_IDLE, S_LOAD, S_STORE} state_t;

  state_t      state_q;
  logic [1:0]  k_q;       // next byte index to issue
  logic        pend_q;    // a read was issued last cycle, its byte is on ram_din now
  logic [1:0]  pidx_q;    // byte lane of the pending read
  logic        plast_q;   // the pending read is the final byte of the load
  logic        done_q;
  logic [31:0] rdata_q;

  logic        active;
  logic        io_block;
  logic        busy;
  logic        lsb_win;
  logic [1:0]  idx;
  logic [31:0] wdata_sh;

  assign lsb_done  = done_q;
  assign lsb_rdata = rdata_q;

  // Arbitration and RAM port drive; everything is quiet while held in reset or frozen.
  // A pending final capture also blocks a restart so the LSB, which holds its
  // request until lsb_done, is not re-served in the cycle before its done pulse.
  always_comb begin
    active   = rdy_in & rst_in;
    io_block = lsb_we & (lsb_addr[17:16] == IO_SEL) & io_buffer_full;
    busy     = (state_q != S_IDLE);
    lsb_win  = active & ~busy & lsb_req & ~done_q & ~pend_q & ~io_block;
    idx      = busy ? k_q : 2'd0;
    if_grant = active & ~busy & ~lsb_win & if_req;
    ram_a    = (busy | lsb_win) ? (lsb_addr + {30'd0, idx}) : if_addr;
    ram_wr   = active & ((lsb_win & lsb_we) | (state_q == S_STORE));
    wdata_sh = lsb_wdata >> {idx, 3'b000};
    ram_dout = ram_wr ? wdata_sh[7:0] : 8'h00;
  end

  // Controller FSM: byte issue sequencing, read-data capture and the done pulse.
  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      state_q <= S_IDLE;
      k_q     <= 2'd0;
      pend_q  <= 1'b0;
      pidx_q  <= 2'd0;
      plast_q <= 1'b0;
      done_q  <= 1'b0;
      rdata_q <= 32'd0;
    end else begin
      done_q <= 1'b0;
      // capture is not gated by rdy_in: the RAM delivers regardless
      if (pend_q) begin
        rdata_q[{pidx_q, 3'b000} +: 8] <= ram_din;
        pend_q <= 1'b0;
        if (plast_q) done_q <= 1'b1;
      end
      if (active) begin
        case (state_q)
          S_IDLE: begin
            if (lsb_win) begin
              k_q <= 2'd1;
              if (lsb_we) begin
                if (lsb_len == 2'd0) done_q  <= 1'b1;
                else                 state_q <= S_STORE;
              end else begin
                rdata_q <= 32'd0;
                pend_q  <= 1'b1;
                pidx_q  <= 2'd0;
                plast_q <= (lsb_len == 2'd0);
                if (lsb_len != 2'd0) state_q <= S_LOAD;
              end
            end
          end
          S_LOAD: begin
            if (lsb_flush) begin
              state_q <= S_IDLE;
              pend_q  <= 1'b0;
              k_q     <= 2'd0;
            end else begin
              pend_q  <= 1'b1;
              pidx_q  <= k_q;
              plast_q <= (k_q == lsb_len);
              k_q     <= k_q + 2'd1;
              if (k_q == lsb_len) begin
                state_q <= S_IDLE;
                k_q     <= 2'd0;
              end
            end
          end
          S_STORE: begin
            k_q <= k_q + 2'd1;
            if (k_q == lsb_len) begin
              state_q <= S_IDLE;
              k_q     <= 2'd0;
              done_q  <= 1'b1;
            end
          end
          default: state_q <= S_IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_mem_ctrl.sv
// tb/tb_mem_ctrl.sv - randomized self-checking bench for mem_ctrl against a transaction-level model
module tb_mem_ctrl;

  logic        clk_in = 1'b0;
  logic        rst_in = 1'b0;
  logic        rdy_in = 1'b1;
  logic        io_buffer_full = 1'b0;
  logic        if_req = 1'b0;
  logic [31:0] if_addr = 32'd0;
  logic        if_grant;
  logic        lsb_req = 1'b0;
  logic        lsb_we = 1'b0;
  logic [1:0]  lsb_len = 2'd0;
  logic [31:0] lsb_addr = 32'd0;
  logic [31:0] lsb_wdata = 32'd0;
  logic        lsb_flush = 1'b0;
  logic        lsb_done;
  logic [31:0] lsb_rdata;
  logic [31:0] ram_a;
  logic        ram_wr;
  logic [7:0]  ram_dout;
  logic [7:0]  ram_din = 8'd0;

  int checks = 0;
  int failures = 0;

  always #5 clk_in = ~clk_in;

  mem_ctrl #(.IO_SEL(2'b11)) dut (
    .clk_in(clk_in), .rst_in(rst_in), .rdy_in(rdy_in), .io_buffer_full(io_buffer_full),
    .if_req(if_req), .if_addr(if_addr), .if_grant(if_grant),
    .lsb_req(lsb_req), .lsb_we(lsb_we), .lsb_len(lsb_len), .lsb_addr(lsb_addr),
    .lsb_wdata(lsb_wdata), .lsb_flush(lsb_flush), .lsb_done(lsb_done), .lsb_rdata(lsb_rdata),
    .ram_a(ram_a), .ram_wr(ram_wr), .ram_dout(ram_dout), .ram_din(ram_din)
  );

  // Sparse RAM: unwritten bytes read back a fixed hash of their address.
  logic [7:0]  mem [logic [31:0]];
  logic [31:0] ra_s = 32'd0;
  logic        wr_s = 1'b0;
  logic [7:0]  do_s = 8'd0;
  logic [31:0] wq_a [$];
  logic [7:0]  wq_d [$];

  function automatic logic [7:0] rd(input logic [31:0] a);
    if (mem.exists(a)) return mem[a];
    return a[7:0] ^ a[15:8] ^ a[31:24] ^ 8'h5a;
  endfunction

  always @(negedge clk_in) begin
    ra_s = ram_a;
    wr_s = ram_wr;
    do_s = ram_dout;
  end

  always @(posedge clk_in) begin
    if (wr_s) begin
      mem[ra_s] = do_s;
      wq_a.push_back(ra_s);
      wq_d.push_back(do_s);
    end
    ram_din <= rd(ra_s);
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic do_fetch(input logic [31:0] base, input int n);
    for (int i = 0; i < n; i++) begin
      if_req  = 1'b1;
      if_addr = base + 32'(i);
      @(negedge clk_in);
      chk("fetch_grant", if_grant, 1);
      chk("fetch_addr", ram_a, base + 32'(i));
      chk("fetch_wr", ram_wr, 0);
      @(posedge clk_in); #1;
    end
    if_req = 1'b0;
  endtask

  // One LSB transaction: optional I/O-full hold of blk cycles, optional rdy_in
  // stall of l cycles starting at issue cycle s. Expected behaviour comes from
  // counting bytes issued: n bytes, one per ready cycle, done one cycle after the
  // last write or two cycles after the last read address.
  task automatic do_lsb(input bit we, input logic [1:0] len, input logic [31:0] addr,
                        input logic [31:0] wd, input bit if_on, input int blk,
                        input int s, input int l);
    int n, issued, last_iss;
    bit fin, exp_done;
    logic [31:0] exp_rd, fa;
    n = int'(len) + 1;
    exp_rd = 32'd0;
    for (int i = 0; i < n; i++) exp_rd |= {24'd0, rd(addr + 32'(i))} << (8 * i);
    wq_a.delete();
    wq_d.delete();
    fa = $urandom;
    lsb_req = 1'b1; lsb_we = we; lsb_len = len; lsb_addr = addr; lsb_wdata = wd;
    if_req = if_on; if_addr = fa;
    if (blk > 0) begin
      io_buffer_full = 1'b1;
      for (int b = 0; b < blk; b++) begin
        @(negedge clk_in);
        chk("io_blk_wr", ram_wr, 0);
        chk("io_blk_grant", if_grant, if_on);
        chk("io_blk_addr", ram_a, fa);
        chk("io_blk_done", lsb_done, 0);
        @(posedge clk_in); #1;
      end
      io_buffer_full = 1'b0;
    end
    issued = 0; last_iss = -10; fin = 1'b0;
    for (int c = 0; c < n + l + 4 && !fin; c++) begin
      rdy_in = !(c >= s && c < s + l);
      @(negedge clk_in);
      if (rdy_in && issued < n) begin
        chk("lsb_addr", ram_a, addr + 32'(issued));
        chk("lsb_wr", ram_wr, we);
        chk("lsb_grant_busy", if_grant, 0);
        if (we) chk("lsb_dout", ram_dout, {24'd0, 8'(wd >> (8 * issued))});
        issued++;
        last_iss = c;
      end else begin
        chk("idle_wr", ram_wr, 0);
        chk("tail_grant", if_grant, rdy_in && issued == n && if_on);
      end
      exp_done = (issued == n) && (c == last_iss + (we ? 1 : 2));
      chk("lsb_done", lsb_done, exp_done);
      if (exp_done) begin
        if (!we) chk("lsb_rdata", lsb_rdata, exp_rd);
        fin = 1'b1;
      end
      @(posedge clk_in); #1;
    end
    lsb_req = 1'b0; rdy_in = 1'b1; if_req = 1'b0;
    if (we) begin
      chk("wr_count", wq_a.size(), n);
      for (int i = 0; i < n && i < wq_a.size(); i++) begin
        chk("wr_addr", wq_a[i], addr + 32'(i));
        chk("wr_data", wq_d[i], {24'd0, 8'(wd >> (8 * i))});
      end
    end
  endtask

  task automatic do_flush_load(input logic [31:0] addr);
    logic [31:0] fa;
    fa = $urandom;
    lsb_req = 1'b1; lsb_we = 1'b0; lsb_len = 2'd3; lsb_addr = addr;
    if_req = 1'b1; if_addr = fa;
    for (int c = 0; c < 6; c++) begin
      if (c == 2) begin lsb_flush = 1'b1; lsb_req = 1'b0; end
      if (c == 3) lsb_flush = 1'b0;
      @(negedge clk_in);
      chk("flush_done", lsb_done, 0);
      if (c < 3) chk("flush_grant_busy", if_grant, 0);
      else begin
        chk("flush_grant_after", if_grant, 1);
        chk("flush_fetch_addr", ram_a, fa);
      end
      @(posedge clk_in); #1;
    end
    if_req = 1'b0;
  endtask

  task automatic do_reset_midload(input logic [31:0] addr);
    logic [31:0] fa;
    fa = $urandom;
    lsb_req = 1'b1; lsb_we = 1'b0; lsb_len = 2'd3; lsb_addr = addr;
    if_req = 1'b1; if_addr = fa;
    @(posedge clk_in); #1;
    @(posedge clk_in); #1;
    @(negedge clk_in);
    chk("pre_rst_rdata", lsb_rdata, {24'd0, rd(addr)});
    #2 rst_in = 1'b0;
    #1;
    chk("rst_async_done", lsb_done, 0);
    chk("rst_async_rdata", lsb_rdata, 0);
    chk("rst_async_grant", if_grant, 0);
    chk("rst_async_wr", ram_wr, 0);
    chk("rst_async_addr", ram_a, fa);
    chk("rst_async_dout", ram_dout, 0);
    @(posedge clk_in); #1;
    lsb_req = 1'b0; if_req = 1'b0; rst_in = 1'b1;
  endtask

  initial begin
    logic [31:0] a, w;
    logic [1:0]  ln;
    bit          we, ifo;
    int          blk, s, l;

    if_req = 1'b1; if_addr = 32'h1234_5678; lsb_req = 1'b1; lsb_we = 1'b1;
    @(negedge clk_in);
    chk("rst_done", lsb_done, 0);
    chk("rst_rdata", lsb_rdata, 0);
    chk("rst_grant", if_grant, 0);
    chk("rst_wr", ram_wr, 0);
    chk("rst_addr", ram_a, 32'h1234_5678);
    chk("rst_dout", ram_dout, 0);
    @(posedge clk_in); #1;
    rst_in = 1'b1; lsb_req = 1'b0; if_req = 1'b0;

    mem[32'h0] = 8'h11; mem[32'h1] = 8'h22; mem[32'h2] = 8'h33; mem[32'h3] = 8'h44;
    do_fetch(32'h0, 4);

    mem[32'h100] = 8'hef; mem[32'h101] = 8'hbe; mem[32'h102] = 8'had; mem[32'h103] = 8'hde;
    do_lsb(1'b0, 2'd3, 32'h100, 32'd0, 1'b1, 0, 0, 0);
    chk("word_load_value", lsb_rdata, 32'hdead_beef);

    do_lsb(1'b1, 2'd1, 32'h200, 32'h0000_a5c3, 1'b1, 0, 0, 0);
    do_lsb(1'b1, 2'd0, 32'h30000, 32'h0000_0077, 1'b1, 5, 0, 0);
    do_flush_load(32'h400);
    do_fetch(32'h800, 2);
    do_lsb(1'b1, 2'd3, 32'h500, 32'h8877_6655, 1'b1, 0, 1, 3);
    do_lsb(1'b0, 2'd3, 32'hffff_fffe, 32'd0, 1'b0, 0, 0, 0);

    for (int it = 0; it < 40; it++) begin
      case ($urandom % 3)
        0: ln = 2'd0;
        1: ln = 2'd1;
        default: ln = 2'd3;
      endcase
      we  = 1'($urandom % 2);
      ifo = 1'($urandom % 2);
      a   = $urandom;
      if ($urandom % 4 == 0) a = 32'hffff_ffff - ($urandom % 3);
      w   = $urandom;
      blk = 0;
      if (we && ($urandom % 3 == 0)) begin
        blk = 1 + int'($urandom % 3);
        a[17:16] = 2'b11;
      end
      s = 1 + int'($urandom % 3);
      l = int'($urandom % 3);
      do_lsb(we, ln, a, w, ifo, blk, s, l);
      if (we) do_lsb(1'b0, ln, a, 32'd0, ifo, 0, s, 0);
      do_fetch($urandom, int'($urandom % 3));
    end

    do_reset_midload(32'h0000_0100);
    do_fetch(32'h0, 4);
    do_lsb(1'b0, 2'd1, 32'h200, 32'd0, 1'b1, 0, 0, 0);
    chk("store_readback", lsb_rdata, 32'h0000_a5c3);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
